// File: rtl/noc_dev_endpoint_if.sv
// rtl/noc_dev_endpoint_if.sv - byte-serial NoC link between switch port and device endpoint
//
// Signals:
//   noc_to_dev_ctl    1 = header/idle byte, 0 = payload byte (switch -> device)
//   noc_to_dev_data   request byte stream (switch -> device)
//   noc_from_dev_ctl  response ctl, idles at 1 (device -> switch)
//   noc_from_dev_data response byte stream, idles at 0x00 (device -> switch)
// Modports:
//   master  switch side (drives requests, receives responses)
//   slave   device side (receives requests, drives responses)

interface noc_dev_endpoint_if;
  logic       noc_to_dev_ctl;
  logic [7:0] noc_to_dev_data;
  logic       noc_from_dev_ctl;
  logic [7:0] noc_from_dev_data;

  modport master (
    output noc_to_dev_ctl,
    output noc_to_dev_data,
    input  noc_from_dev_ctl,
    input  noc_from_dev_data
  );

  modport slave (
    input  noc_to_dev_ctl,
    input  noc_to_dev_data,
    output noc_from_dev_ctl,
    output noc_from_dev_data
  );
endinterface

// File: rtl/noc_dev_endpoint.sv
// rtl/noc_dev_endpoint.sv - device-side terminal of the NoC byte-serial link
//
// Parses read/write request packets, executes them against a local
// byte-addressed memory and streams a response packet back.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high
//   link   noc_dev_endpoint_if.slave: request stream in, response stream out
//   busy   high while a response is on the wire
//   drop   one-cycle pulse when a request header is discarded (response in flight)

module noc_dev_endpoint #(
  parameter int MEM_BYTES = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  noc_dev_endpoint_if.slave    link,
  output logic                 busy,
  output logic                 drop
);

  localparam int AW = $clog2(MEM_BYTES);

  typedef enum logic [2:0] {RX_IDLE, RX_SID, RX_ADDR, RX_DATA, RX_DISCARD} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_HDR, TX_SID, TX_BODY} tx_state_t;

  logic [7:0] mem [MEM_BYTES];
  logic [7:0] mem_rdata;

  logic       in_ctl;
  logic [7:0] in_data;
  assign in_ctl  = link.noc_to_dev_ctl;
  assign in_data = link.noc_to_dev_data;

  rx_state_t rx_state, rx_next;
  logic          rx_wr;
  logic [1:0]    rx_acode;
  logic [2:0]    rx_dcode;
  logic [7:0]    rx_sid;
  logic [7:0]    rx_cnt;
  logic [AW-1:0] rx_addr;

  tx_state_t tx_state, tx_next;
  logic          tx_wr;
  logic [2:0]    tx_dcode;
  logic [7:0]    tx_sid;
  logic [7:0]    tx_cnt;
  logic [7:0]    tx_len;
  logic [AW-1:0] tx_addr;

  logic          hdr_seen, cmd_ok, tx_active;
  logic [7:0]    alen_last, dlen_last;
  logic [AW-1:0] addr_cur;
  logic          accept_hdr, drop_next, sid_we, addr_we, mem_we, tx_start, tx_rd_en;
  logic          ctl_next, busy_next;
  logic [7:0]    data_next;

  // A new header is judged against the TX state rather than the busy flop:
  // busy rises one edge after the launch, and a header arriving on that edge
  // must already see the response as in flight.
  assign tx_active = (tx_state != TX_IDLE);
  assign hdr_seen  = in_ctl && (in_data != 8'h00);
  assign cmd_ok    = (in_data[2:0] == 3'b001) || (in_data[2:0] == 3'b010);
  assign alen_last = (8'd1 << rx_acode) - 8'd1;
  assign dlen_last = (8'd1 << rx_dcode) - 8'd1;

  // Only the first two little-endian address bytes can reach bits below AW;
  // later bytes contribute nothing, which discards the upper address bits.
  assign addr_cur = rx_addr | AW'((rx_cnt == 8'd0) ? {8'h00, in_data} :
                                  (rx_cnt == 8'd1) ? {in_data, 8'h00} : 16'h0000);

  // ---------------- RX state machine ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rx_state <= RX_IDLE;
    else       rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    if (in_ctl) begin
      // Any ctl=1 byte is evaluated as if in RX_IDLE, aborting a packet in progress.
      if (in_data == 8'h00)          rx_next = RX_IDLE;
      else if (tx_active || !cmd_ok) rx_next = RX_DISCARD;
      else                           rx_next = RX_SID;
    end else begin
      case (rx_state)
        RX_SID:  rx_next = RX_ADDR;
        RX_ADDR: if (rx_cnt == alen_last) rx_next = rx_wr ? RX_DATA : RX_IDLE;
        RX_DATA: if (rx_cnt == dlen_last) rx_next = RX_IDLE;
        default: rx_next = rx_state;
      endcase
    end
  end

  always_comb begin
    accept_hdr = hdr_seen && !tx_active && cmd_ok;
    drop_next  = hdr_seen && tx_active;
    sid_we     = !in_ctl && (rx_state == RX_SID);
    addr_we    = !in_ctl && (rx_state == RX_ADDR);
    mem_we     = !in_ctl && (rx_state == RX_DATA);
    tx_start   = (addr_we && (rx_cnt == alen_last) && !rx_wr) ||
                 (mem_we && (rx_cnt == dlen_last));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_wr    <= 1'b0;
      rx_acode <= 2'd0;
      rx_dcode <= 3'd0;
      rx_sid   <= 8'h00;
      rx_cnt   <= 8'd0;
      rx_addr  <= '0;
    end else if (accept_hdr) begin
      rx_acode <= in_data[7:6];
      rx_dcode <= in_data[5:3];
      rx_wr    <= in_data[1];
      rx_addr  <= '0;
    end else if (sid_we) begin
      rx_sid <= in_data;
      rx_cnt <= 8'd0;
    end else if (addr_we) begin
      rx_addr <= addr_cur;
      rx_cnt  <= (rx_cnt == alen_last) ? 8'd0 : rx_cnt + 8'd1;
    end else if (mem_we) begin
      rx_addr <= rx_addr + AW'(1);
      rx_cnt  <= rx_cnt + 8'd1;
    end
  end

  // Single-port memory; writes happen only while TX is idle, so the read
  // port is never active in the same cycle as a write.
  assign tx_rd_en = !tx_wr && ((tx_state == TX_SID) || (tx_state == TX_BODY));

  always_ff @(posedge clk) begin
    if (mem_we)   mem[rx_addr] <= in_data;
    if (tx_rd_en) mem_rdata    <= mem[tx_addr];
  end

  // ---------------- TX state machine ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tx_state <= TX_IDLE;
    else       tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE: if (tx_start) tx_next = TX_HDR;
      TX_HDR:  tx_next = TX_SID;
      TX_SID:  tx_next = TX_BODY;
      TX_BODY: if (tx_cnt == tx_len - 8'd1) tx_next = TX_IDLE;
      default: tx_next = TX_IDLE;
    endcase
  end

  // Next values for the registered outputs. The memory read for body byte n
  // is issued one edge ahead, so mem_rdata already holds it in TX_BODY.
  always_comb begin
    ctl_next  = 1'b1;
    data_next = 8'h00;
    busy_next = 1'b0;
    case (tx_state)
      TX_HDR: begin
        ctl_next  = 1'b1;
        data_next = tx_wr ? 8'h04 : {2'b00, tx_dcode, 3'b011};
        busy_next = 1'b1;
      end
      TX_SID: begin
        ctl_next  = 1'b0;
        data_next = tx_sid;
        busy_next = 1'b1;
      end
      TX_BODY: begin
        ctl_next  = 1'b0;
        data_next = tx_wr ? 8'h00 : mem_rdata;
        busy_next = 1'b1;
      end
      default: begin
        ctl_next  = 1'b1;
        data_next = 8'h00;
        busy_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wr    <= 1'b0;
      tx_dcode <= 3'd0;
      tx_sid   <= 8'h00;
      tx_cnt   <= 8'd0;
      tx_len   <= 8'd1;
      tx_addr  <= '0;
    end else if (tx_start) begin
      tx_wr    <= rx_wr;
      tx_dcode <= rx_dcode;
      tx_sid   <= rx_sid;
      tx_cnt   <= 8'd0;
      tx_len   <= rx_wr ? 8'd1 : (8'd1 << rx_dcode);
      tx_addr  <= addr_cur;
    end else if (tx_state == TX_SID) begin
      tx_addr <= tx_addr + AW'(1);
    end else if (tx_state == TX_BODY) begin
      tx_addr <= tx_addr + AW'(1);
      tx_cnt  <= tx_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      link.noc_from_dev_ctl  <= 1'b1;
      link.noc_from_dev_data <= 8'h00;
      busy                   <= 1'b0;
      drop                   <= 1'b0;
    end else begin
      link.noc_from_dev_ctl  <= ctl_next;
      link.noc_from_dev_data <= data_next;
      busy                   <= busy_next;
      drop                   <= drop_next;
    end
  end

endmodule

// File: tb/tb_noc_dev_endpoint.sv
// tb/tb_noc_dev_endpoint.sv - self-checking bench for noc_dev_endpoint
//
// Drives request packets through the link interface and compares every
// output on every cycle against an expected timeline built from a
// reference memory and packet-level response rules.

module tb_noc_dev_endpoint;

  localparam int MEM  = 256;
  localparam int NMAX = 16384;

  logic clk = 1'b0;
  logic reset;
  logic busy, drop;

  noc_dev_endpoint_if link_if();

  noc_dev_endpoint #(.MEM_BYTES(MEM)) dut (
    .clk   (clk),
    .reset (reset),
    .link  (link_if),
    .busy  (busy),
    .drop  (drop)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  // Expected outputs as seen after each numbered rising edge.
  logic       exp_ctl  [NMAX];
  logic [7:0] exp_data [NMAX];
  logic       exp_busy [NMAX];
  logic       exp_drop [NMAX];

  logic [7:0] ref_mem [MEM];
  logic [7:0] wbuf [128];
  logic [7:0] resp_q [$];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s edge=%0d observed=%02h expected=%02h", tag, edge_n, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    edge_n++;
    if (edge_n >= NMAX - 300) begin
      errors++;
      $display("FAIL edge_budget edge=%0d limit=%0d", edge_n, NMAX - 300);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "edge budget exhausted");
    end
    @(negedge clk);
    chk("ctl",  {7'd0, link_if.noc_from_dev_ctl}, {7'd0, exp_ctl[edge_n]});
    chk("data", link_if.noc_from_dev_data, exp_data[edge_n]);
    chk("busy", {7'd0, busy}, {7'd0, exp_busy[edge_n]});
    chk("drop", {7'd0, drop}, {7'd0, exp_drop[edge_n]});
  endtask

  task automatic send(input logic c, input logic [7:0] d);
    link_if.noc_to_dev_ctl  = c;
    link_if.noc_to_dev_data = d;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b1, 8'h00);
  endtask

  // Idle until the next edge is one at which the model shows no response.
  task automatic wait_idle();
    int guard;
    guard = 0;
    while (exp_busy[edge_n + 1] && guard < 1000) begin
      send(1'b1, 8'h00);
      guard++;
    end
  endtask

  // Response bytes in resp_q go on the wire after edges k+1, k+2, ...
  task automatic schedule(input int k);
    for (int i = 0; i < resp_q.size(); i++) begin
      exp_ctl [k + 1 + i] = (i == 0);
      exp_data[k + 1 + i] = resp_q[i];
      exp_busy[k + 1 + i] = 1'b1;
    end
  endtask

  // Send one request packet. n_data < 0 sends the full write payload;
  // a smaller count stops early (the caller then injects a header).
  task automatic request(input bit wr, input int acode, input int dcode,
                         input logic [7:0] sid, input logic [63:0] addr,
                         input int n_data);
    int alen, dlen, nd, e, eff;
    bit acc;
    longint unsigned a_used;
    logic [7:0] hdr;
    alen = 1 << acode;
    dlen = 1 << dcode;
    hdr  = 8'((acode << 6) + (dcode << 3) + (wr ? 2 : 1));
    e    = edge_n + 1;
    acc  = !exp_busy[e];
    if (!acc) exp_drop[e] = 1'b1;
    send(1'b1, hdr);
    send(1'b0, sid);
    a_used = 0;
    for (int i = 0; i < alen; i++) begin
      a_used = a_used + (longint'(addr[8*i +: 8]) << (8 * i));
      send(1'b0, addr[8*i +: 8]);
    end
    eff = int'(a_used % MEM);
    nd  = 0;
    if (wr) begin
      nd = (n_data < 0) ? dlen : n_data;
      for (int i = 0; i < nd; i++) begin
        if (acc) ref_mem[(eff + i) % MEM] = wbuf[i];
        send(1'b0, wbuf[i]);
      end
    end
    if (acc && (!wr || nd == dlen)) begin
      resp_q.delete();
      if (wr) begin
        resp_q.push_back(8'h04);
        resp_q.push_back(sid);
        resp_q.push_back(8'h00);
      end else begin
        resp_q.push_back(8'(8'h03 + (dcode << 3)));
        resp_q.push_back(sid);
        for (int i = 0; i < dlen; i++) resp_q.push_back(ref_mem[(eff + i) % MEM]);
      end
      schedule(edge_n);
    end
  endtask

  bit         r_wr;
  int         r_ac, r_dc;
  logic [7:0] r_sid;
  logic [63:0] r_addr;

  initial begin
    for (int i = 0; i < NMAX; i++) begin
      exp_ctl[i] = 1'b1; exp_data[i] = 8'h00; exp_busy[i] = 1'b0; exp_drop[i] = 1'b0;
    end
    reset = 1'b1;
    link_if.noc_to_dev_ctl  = 1'b1;
    link_if.noc_to_dev_data = 8'h00;
    @(negedge clk);
    chk("reset_ctl",  {7'd0, link_if.noc_from_dev_ctl}, 8'h01);
    chk("reset_data", link_if.noc_from_dev_data, 8'h00);
    chk("reset_busy", {7'd0, busy}, 8'h00);
    chk("reset_drop", {7'd0, drop}, 8'h00);
    reset = 1'b0;
    idle(2);

    // Fill the whole memory with random data so every read has a known value.
    for (int h = 0; h < 2; h++) begin
      for (int i = 0; i < 128; i++) wbuf[i] = 8'($urandom);
      request(1'b1, 0, 7, 8'(8'hC0 + h), 64'(h * 128), -1);
      wait_idle();
    end

    // Write 11 22 33 44 at 0x10, then read it back.
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
    request(1'b1, 0, 2, 8'h5A, 64'h10, -1);
    wait_idle();
    request(1'b0, 0, 2, 8'h5A, 64'h10, -1);
    wait_idle();

    // Two-byte address wrapping past the top of memory; upper byte ignored.
    request(1'b0, 1, 2, 8'h21, 64'h00FE, -1);
    wait_idle();
    request(1'b0, 1, 2, 8'h22, 64'h07FE, -1);
    wait_idle();

    // Unsupported command: silently discarded, then a normal read.
    send(1'b1, 8'b00_010_101);
    for (int i = 0; i < 4; i++) send(1'b0, 8'($urandom));
    request(1'b0, 0, 1, 8'h31, 64'h10, -1);
    wait_idle();

    // Second header while a 10-byte response is in flight is dropped.
    request(1'b0, 0, 3, 8'h41, 64'h20, -1);
    request(1'b0, 0, 0, 8'h42, 64'h30, -1);
    wait_idle();

    // Reset during the 5th body byte of an 8-byte read response.
    request(1'b0, 0, 3, 8'h51, 64'h60, -1);
    idle(7);
    reset = 1'b1;
    #1;
    chk("rst_mid_ctl",  {7'd0, link_if.noc_from_dev_ctl}, 8'h01);
    chk("rst_mid_data", link_if.noc_from_dev_data, 8'h00);
    chk("rst_mid_busy", {7'd0, busy}, 8'h00);
    chk("rst_mid_drop", {7'd0, drop}, 8'h00);
    for (int i = edge_n + 1; i < NMAX; i++) begin
      exp_ctl[i] = 1'b1; exp_data[i] = 8'h00; exp_busy[i] = 1'b0; exp_drop[i] = 1'b0;
    end
    idle(2);
    reset = 1'b0;
    idle(1);
    for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
    request(1'b1, 0, 2, 8'h52, 64'h70, -1);
    wait_idle();
    request(1'b0, 0, 2, 8'h53, 64'h70, -1);
    wait_idle();

    // Header injected after 2 of 4 write data bytes aborts the write.
    wbuf[0] = 8'hAA; wbuf[1] = 8'hBB; wbuf[2] = 8'hCC; wbuf[3] = 8'hDD;
    request(1'b1, 0, 2, 8'h61, 64'h40, 2);
    request(1'b0, 0, 2, 8'h62, 64'h3F, -1);
    wait_idle();

    // Randomized traffic, sometimes issued before the previous response ends.
    for (int n = 0; n < 30; n++) begin
      r_wr   = 1'($urandom_range(0, 1));
      r_ac   = $urandom_range(0, 3);
      r_dc   = $urandom_range(0, 4);
      r_sid  = 8'($urandom);
      r_addr = {$urandom, $urandom};
      for (int i = 0; i < 128; i++) wbuf[i] = 8'($urandom);
      if ($urandom_range(0, 3) != 0) wait_idle();
      else idle($urandom_range(0, 2));
      request(r_wr, r_ac, r_dc, r_sid, r_addr, -1);
    end
    wait_idle();
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
